// File: rtl/bram_req_adapter.sv
// Valid/grant request front end for a single-port byte-write BRAM: range check,
// same-cycle BRAM issue, one registered stage and a 2-entry in-order response buffer.
module bram_req_adapter #(
    parameter int unsigned NB_COL    = 4,
    parameter int unsigned COL_WIDTH = 8,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    localparam int unsigned DataWidth = NB_COL * COL_WIDTH,
    localparam int unsigned IdxWidth  = $clog2(RAM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [NB_COL-1:0]    be_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o,
    output logic                 mem_req_o,
    output logic [IdxWidth-1:0]  mem_addr_o,
    output logic [NB_COL-1:0]    mem_bwe_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    localparam int unsigned OffBits  = (NB_COL > 1) ? $clog2(NB_COL) : 0;
    localparam logic [31:0] WinBytes = 32'(RAM_DEPTH * NB_COL);

    logic [31:0]          offset;
    logic                 in_range;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic [2:0]           occ;
    logic [DataWidth-1:0] push_rdata;

    logic                 s1_valid;
    logic                 s1_is_read;
    logic                 s1_err;

    logic [DataWidth-1:0] fifo_rdata [2];
    logic                 fifo_err   [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_count;

    assign offset   = addr_i - BASE_ADDR;
    assign in_range = offset < WinBytes;

    // Grant looks at what the buffer will hold after this cycle's pop, so a
    // full buffer still accepts while it is being drained.
    assign pop    = rvalid_o & rready_i;
    assign occ    = {2'b00, s1_valid} + {1'b0, fifo_count};
    assign gnt_o  = rst_ni & ((occ - {2'b00, pop}) < 3'd2);
    assign accept = req_i & gnt_o;

    assign mem_req_o   = accept & in_range & (~we_i | (be_i != '0));
    assign mem_addr_o  = offset[OffBits +: IdxWidth];
    assign mem_bwe_o   = (mem_req_o & we_i) ? be_i : '0;
    assign mem_wdata_o = wdata_i;

    // Read data is taken in the cycle after the BRAM read, before any later
    // write can move the BRAM port.
    assign push       = s1_valid;
    assign push_rdata = (s1_is_read & ~s1_err) ? mem_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            s1_valid <= accept;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        s1_is_read <= ~we_i;
        s1_err     <= ~in_range;
        if (push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= s1_err;
        end
    end

    assign rvalid_o = fifo_count != 2'd0;
    assign rdata_o  = rvalid_o ? fifo_rdata[rd_ptr] : '0;
    assign err_o    = rvalid_o ? fifo_err[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_bram_req_adapter.sv
// Bench for bram_req_adapter: directed vector table, back-pressure and reset
// sequences, and a random stream checked against a reference memory.
module tb_bram_req_adapter;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic        rready_i;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_bwe_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int checks   = 0;
    int failures = 0;

    bram_req_adapter #(
        .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(1024), .BASE_ADDR(32'h1000)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_bwe_o(mem_bwe_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Read-first BRAM model: output register reloads on every enabled cycle.
    logic [31:0] bram [1024];
    initial begin
        for (int i = 0; i < 1024; i++) bram[i] = 32'h0;
        mem_rdata_i = 32'h0;
    end
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            mem_rdata_i <= bram[mem_addr_o];
            for (int b = 0; b < 4; b++)
                if (mem_bwe_o[b]) bram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni && dut.s1_valid && dut.fifo_count == 2'd2 && !(rvalid_o && rready_i)) begin
            failures++;
            $display("FAIL fifo_overflow actual=push_into_full required=no_push");
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        e_gnt;
        logic        e_mreq;
        logic        addr_chk;
        logic [9:0]  e_maddr;
        logic [3:0]  e_bwe;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(logic req, logic [31:0] addr, logic we, logic [3:0] be,
                                logic [31:0] wd, logic gnt, logic mreq, logic achk,
                                logic [9:0] maddr, logic [3:0] bwe, logic rv,
                                logic [31:0] rd, logic er);
        vec_t v;
        v.req = req; v.addr = addr; v.we = we; v.be = be; v.wdata = wd;
        v.e_gnt = gnt; v.e_mreq = mreq; v.addr_chk = achk; v.e_maddr = maddr;
        v.e_bwe = bwe; v.e_rvalid = rv; v.e_rdata = rd; v.e_err = er;
        return v;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       expq[$];
    logic [31:0] ref_mem [1024];
    vec_t        vecs [13];

    initial begin
        logic [31:0] bp_exp [4];
        int grants, nreq, nresp, issued, cyc;
        bit have, did_reset;
        logic [31:0] off;
        resp_t e;

        rst_ni = 1'b0; req_i = 1'b1; addr_i = 32'h1008; we_i = 1'b0;
        be_i = 4'h0; wdata_i = 32'h0; rready_i = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

        // Reset held for three cycles with a pending request
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i); #1;
            chk("rst_gnt", 32'(gnt_o), 32'h0);
            chk("rst_mem_req", 32'(mem_req_o), 32'h0);
            chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1; req_i = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(gnt_o), 32'h1);
        chk("post_rst_rdata", rdata_o, 32'h0);
        chk("post_rst_err", 32'(err_o), 32'h0);

        // Response of vector i appears at vector i+2 with rready held high
        vecs[0]  = mk(1, 32'h1008, 1, 4'hF, 32'hDEADBEEF, 1, 1, 1, 10'd2,    4'hF, 0, 32'h0, 0);
        vecs[1]  = mk(1, 32'h1008, 0, 4'h0, 32'h0,       1, 1, 1, 10'd2,    4'h0, 0, 32'h0, 0);
        vecs[2]  = mk(1, 32'h100C, 1, 4'h3, 32'h00001234, 1, 1, 1, 10'd3,   4'h3, 1, 32'h0, 0);
        vecs[3]  = mk(1, 32'h100C, 0, 4'h0, 32'h0,       1, 1, 1, 10'd3,    4'h0, 1, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 32'h0FFC, 0, 4'h0, 32'h0,       1, 0, 0, 10'd0,    4'h0, 1, 32'h0, 0);
        vecs[5]  = mk(1, 32'h2000, 0, 4'h0, 32'h0,       1, 0, 0, 10'd0,    4'h0, 1, 32'h00001234, 0);
        vecs[6]  = mk(1, 32'h1FFC, 0, 4'h0, 32'h0,       1, 1, 1, 10'd1023, 4'h0, 1, 32'h0, 1);
        vecs[7]  = mk(1, 32'h1FFD, 1, 4'h8, 32'hA5000000, 1, 1, 1, 10'd1023, 4'h8, 1, 32'h0, 1);
        vecs[8]  = mk(1, 32'h1FFE, 0, 4'h0, 32'h0,       1, 1, 1, 10'd1023, 4'h0, 1, 32'h0, 0);
        vecs[9]  = mk(1, 32'h1011, 1, 4'h0, 32'hFFFFFFFF, 1, 0, 1, 10'd4,   4'h0, 1, 32'h0, 0);
        vecs[10] = mk(0, 32'h0,    0, 4'h0, 32'h0,       1, 0, 0, 10'd0,    4'h0, 1, 32'hA5000000, 0);
        vecs[11] = mk(0, 32'h0,    0, 4'h0, 32'h0,       1, 0, 0, 10'd0,    4'h0, 1, 32'h0, 0);
        vecs[12] = mk(0, 32'h0,    0, 4'h0, 32'h0,       1, 0, 0, 10'd0,    4'h0, 0, 32'h0, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk_i);
            req_i = vecs[i].req; addr_i = vecs[i].addr; we_i = vecs[i].we;
            be_i = vecs[i].be; wdata_i = vecs[i].wdata; rready_i = 1'b1;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt_o), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].e_mreq));
            chk($sformatf("v%0d_mem_bwe", i), 32'(mem_bwe_o), 32'(vecs[i].e_bwe));
            if (vecs[i].addr_chk)
                chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr_o), 32'(vecs[i].e_maddr));
            if (vecs[i].we && vecs[i].e_mreq)
                chk($sformatf("v%0d_mem_wdata", i), mem_wdata_o, vecs[i].wdata);
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid_o), 32'(vecs[i].e_rvalid));
            chk($sformatf("v%0d_rdata", i), rdata_o, vecs[i].e_rdata);
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
        end

        // Back-pressure: four reads of words 0..3 with rready low
        bp_exp[0] = 32'h0; bp_exp[1] = 32'h0; bp_exp[2] = 32'hDEADBEEF; bp_exp[3] = 32'h00001234;
        grants = 0; nreq = 0; nresp = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            rready_i = 1'b0; req_i = 1'b1; we_i = 1'b0; be_i = 4'h0;
            addr_i = 32'h1000 + 32'(nreq) * 4;
            #1;
            if (gnt_o) begin grants++; nreq++; end
        end
        chk("bp_grants", 32'(grants), 32'd2);
        chk("bp_gnt_low", 32'(gnt_o), 32'h0);
        chk("bp_stall_rvalid", 32'(rvalid_o), 32'h1);
        for (int c = 0; c < 20 && nresp < 4; c++) begin
            @(negedge clk_i);
            rready_i = 1'b1;
            req_i = (nreq < 4);
            addr_i = 32'h1000 + 32'(nreq) * 4;
            #1;
            if (c == 0) chk("bp_gnt_reassert", 32'(gnt_o), 32'h1);
            if (rvalid_o && rready_i) begin
                chk($sformatf("bp_rdata%0d", nresp), rdata_o, bp_exp[nresp]);
                chk($sformatf("bp_err%0d", nresp), 32'(err_o), 32'h0);
                nresp++;
            end
            if (req_i && gnt_o) nreq++;
        end
        chk("bp_resp_count", 32'(nresp), 32'd4);
        @(negedge clk_i);
        req_i = 1'b0;
        #1;
        chk("bp_no_dup", 32'(rvalid_o), 32'h0);

        // Random stream on words 32..47 with one reset midway
        issued = 0; cyc = 0; have = 0; did_reset = 0;
        while (issued < 100 && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            if (!did_reset && issued == 50) begin
                rst_ni = 1'b0; req_i = 1'b0;
                #1;
                chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
                @(negedge clk_i);
                rst_ni = 1'b1;
                expq.delete();
                did_reset = 1;
                #1;
                chk("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
                continue;
            end
            if (!have) begin
                we_i = 1'($urandom_range(0, 1));
                be_i = 4'($urandom_range(0, 15));
                wdata_i = $urandom;
                if ($urandom_range(0, 7) == 0)
                    addr_i = ($urandom_range(0, 1) == 0) ? 32'h0FF0 : 32'h2000 + 32'($urandom_range(0, 63));
                else
                    addr_i = 32'h1000 + 32'($urandom_range(32, 47)) * 4 + 32'($urandom_range(0, 3));
                have = 1;
            end
            rready_i = ($urandom_range(0, 3) != 0);
            req_i = ($urandom_range(0, 5) != 0);
            #1;
            if (rvalid_o && rready_i) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stream_unexpected_resp actual=rvalid required=no_response");
                end else begin
                    e = expq.pop_front();
                    chk("stream_rdata", rdata_o, e.data);
                    chk("stream_err", 32'(err_o), 32'(e.err));
                end
            end
            if (req_i && gnt_o) begin
                off = addr_i - 32'h1000;
                if (off >= 32'd4096) begin
                    e.data = 32'h0; e.err = 1'b1;
                end else if (we_i) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) ref_mem[off[11:2]][b*8 +: 8] = wdata_i[b*8 +: 8];
                    e.data = 32'h0; e.err = 1'b0;
                end else begin
                    e.data = ref_mem[off[11:2]]; e.err = 1'b0;
                end
                expq.push_back(e);
                have = 0;
                issued++;
            end
        end
        chk("stream_issued", 32'(issued), 32'd100);

        for (int c = 0; c < 20 && expq.size() > 0; c++) begin
            @(negedge clk_i);
            req_i = 1'b0; rready_i = 1'b1;
            #1;
            if (rvalid_o) begin
                e = expq.pop_front();
                chk("drain_rdata", rdata_o, e.data);
                chk("drain_err", 32'(err_o), 32'(e.err));
            end
        end
        chk("drain_left", 32'(expq.size()), 32'd0);
        @(negedge clk_i);
        #1;
        chk("final_rvalid", 32'(rvalid_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_req_adapter.md
# bram_req_adapter

Request/response front end sitting directly upstream of the single-port byte-write BRAM in the FPGA memory subsystem. Accepts byte-addressed requests on a valid/grant interface, checks the address range, drives the BRAM port, captures read data in the cycle it is valid, and returns in-order responses through a 2-entry buffer with ready back-pressure. Sustains one request per cycle when the response side is not stalled.

## Interface
- NB_COL, 4, byte lanes per word; also the BRAM column count
- COL_WIDTH, 8, bits per lane
- RAM_DEPTH, 1024, BRAM words
- BASE_ADDR, 32'h0, byte base address of the BRAM window; NB_COL*COL_WIDTH/8-aligned
- DataWidth, NB_COL*COL_WIDTH (localparam)
- IdxWidth, $clog2(RAM_DEPTH) (localparam)
- clk_i  in  1  clock, single clock domain
- rst_ni  in  1  reset, synchronous, active-low
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle; handshake is req_i & gnt_o
- addr_i  in  32  byte address
- we_i  in  1  1 = write, 0 = read
- be_i  in  NB_COL  write byte enables; ignored for reads
- wdata_i  in  DataWidth  write data
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed when rvalid_o & rready_i
- rdata_o  out  DataWidth  read data; 0 for write and error responses
- err_o  out  1  response is an address error
- mem_req_o  out  1  BRAM request
- mem_addr_o  out  IdxWidth  BRAM word index
- mem_bwe_o  out  NB_COL  BRAM byte write enables; all 0 for reads
- mem_wdata_o  out  DataWidth  BRAM write data
- mem_rdata_i  in  DataWidth  BRAM read data, valid the cycle after a read request

## Operation
- Offset = addr_i - BASE_ADDR (32-bit, wrapping). In range iff offset < RAM_DEPTH*NB_COL. Word index = offset / NB_COL. Low log2(NB_COL) address bits are ignored, so unaligned addresses access the containing word.
- pop = rvalid_o & rready_i. occ = s1_valid + fifo_count (0..2).
- gnt_o = rst_ni & ((occ - pop) < 2). This is combinational on rready_i and does not depend on req_i.
- On accept, a BRAM access is issued in the same cycle: mem_req_o = accept & in_range & (~we_i | (be_i != 0)).
  - Read: mem_bwe_o = 0.
  - Write: mem_bwe_o = be_i, mem_wdata_o = wdata_i.
  - mem_addr_o = word index.
  - A write with be_i == 0 issues no BRAM access and still produces a normal response.
  - An out-of-range request issues no BRAM access and produces an err_o = 1 response with rdata 0.
- Stage s1 (registered): valid, is_read, err. The cycle after accept, s1 pushes to the FIFO unconditionally. The pushed rdata is mem_rdata_i if is_read & ~err, else 0. Capture happens at the edge ending the cycle after the BRAM read. A following partial-byte write that moves the BRAM read address therefore cannot corrupt it.
- Response FIFO: 2 entries of {rdata, err}, with wrapping 1-bit read/write pointers and a 2-bit count. Pushes and pops in the same cycle are allowed. Overflow is impossible by the gnt_o rule; the bench asserts this.
- rvalid_o = fifo_count != 0. rdata_o and err_o come from the FIFO head, and are 0 when rvalid_o = 0.
- Responses are strictly in accept order, including error and zero-be responses.

## Timing
- Reset (rst_ni low at an edge) sets s1_valid = 0, FIFO count and pointers = 0.
- While rst_ni is low: gnt_o = 0 and mem_req_o = 0.
- After reset: rvalid_o = 0, rdata_o = 0, err_o = 0.
- Reset mid-operation discards all in-flight and buffered responses. No response is emitted for them.
- Latency: request accepted in cycle t → response at rvalid_o in cycle t+2. Cycle t+1 is the BRAM read-data cycle.
- Throughput: with rready_i held high, one accept per cycle indefinitely.
- Stall: with rready_i low, at most 2 requests are accepted, then gnt_o = 0.
  - gnt_o reasserts in the same cycle rready_i rises with rvalid_o = 1.
- Simultaneous push and pop with FIFO full is legal; count stays 2.
- rdata_o and err_o are stable while rvalid_o = 1 and rready_i = 0.

## Test plan
- Reset: hold rst_ni low 3 cycles with req_i = 1. Required: gnt_o = 0, mem_req_o = 0, rvalid_o = 0 throughout; after release, gnt_o = 1.
- Write then read, BASE_ADDR = 32'h1000:
  - Write 0x1008, be 4'b1111, data 0xDEADBEEF → mem_addr_o = 2, mem_bwe_o = 4'hF, response err 0, rdata 0.
  - Read 0x1008 → rdata_o = 0xDEADBEEF at t+2.
- Partial write hazard:
  - Back-to-back: read 0x1008, then write 0x100C with be 4'b0011 data 0x0000_1234.
  - Required: read response = 0xDEADBEEF; later read 0x100C → 0x0000_1234.
- Back-pressure:
  - rready_i = 0, issue 4 reads to words 0..3. Required: exactly 2 grants, gnt_o = 0 afterwards.
  - Raise rready_i. Required: responses for words 0..3 in order, no loss or duplication.
- Range errors:
  - Read 0x0FFC and read 0x1000 + 4096 (RAM_DEPTH 1024). Required: err_o = 1, rdata_o = 0, mem_req_o = 0.
  - Read 0x1FFC. Required: in range, word 1023.
- Streaming plus reset:
  - 100 random reads/writes with random rready_i; the scoreboard matches a reference memory.
  - Assert rst_ni low for 1 cycle mid-stream. Required: no responses for pre-reset requests; memory contents preserved.
